// File: rtl/pattern_reduce_stream.sv
// Streaming pattern reduction: the operand arrives in CHUNK-bit beats and each term is evaluated as its bits arrive.
// The reduced value f and the count of true terms are offered on a valid/ready output.
module pattern_reduce_stream #(
   parameter int N_IN  = 230,
   parameter int CHUNK = 16,
   parameter int CW    = $clog2(N_IN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CHUNK-1:0] in_data,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             f,
   output logic [CW-1:0]    cnt
);

   localparam int NCH        = (N_IN + CHUNK - 1) / CHUNK;
   localparam int LAST_VALID = N_IN - (NCH - 1) * CHUNK;
   localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW         = $clog2(CHUNK + 2);
   localparam int SW         = ((CW > PW) ? CW : PW) + 1;
   localparam logic [1:0] STEP = 2'(CHUNK % 3);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t           state_q, state_d;
   logic [CHW-1:0]   chunk_q, chunk_d;
   logic [1:0]       phase_q, phase_d;
   logic             held_q, held_d;
   logic             acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic             f_q, f_d;

   logic             first, last;
   logic [1:0]       phase_cur, mode_cur;
   logic [CHUNK-1:0] data_m;
   logic [CHUNK:0]   term, en, hits;
   logic [PW-1:0]    pop;
   logic             red_or, red_and, red_xor;
   logic             acc_base, acc_new;
   logic [CW-1:0]    cnt_base, cnt_new;
   logic [SW-1:0]    cnt_sum;

   function automatic logic gate(input logic [1:0] ph, input logic a, input logic b);
      case (ph)
         2'd0:    return a & b;
         2'd1:    return ~a;
         default: return a | b;
      endcase
   endfunction

   function automatic logic [1:0] phase_add(input logic [1:0] p, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, p} + {1'b0, k};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   assign first     = (state_q == IDLE);
   assign last      = first ? (NCH == 1) : (chunk_q == CHW'(NCH - 1));
   assign phase_cur = first ? 2'd0 : phase_q;
   assign mode_cur  = first ? mode : mode_q;

   // Bits past the operand end read as zero, which also supplies a_N_IN = 0 for the tail term.
   generate
      for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
         localparam logic [1:0] OFF = 2'(gi % 3);
         if (gi >= LAST_VALID) begin : g_mask
            assign data_m[gi] = in_data[gi] & ~last;
         end else begin : g_pass
            assign data_m[gi] = in_data[gi];
         end
         if (gi == CHUNK - 1) begin : g_edge
            if (LAST_VALID == CHUNK) begin : g_tail
               assign en[gi] = last;
            end else begin : g_none
               assign en[gi] = 1'b0;
            end
            assign term[gi] = gate(phase_add(phase_cur, OFF), data_m[gi], 1'b0);
         end else begin : g_inner
            if (gi < LAST_VALID) begin : g_always
               assign en[gi] = 1'b1;
            end else begin : g_notlast
               assign en[gi] = ~last;
            end
            assign term[gi] = gate(phase_add(phase_cur, OFF), data_m[gi], data_m[gi+1]);
         end
      end
   endgenerate

   // Term left open by the previous chunk: its top bit was held, its neighbour is bit 0 here.
   assign en[CHUNK]   = ~first;
   assign term[CHUNK] = gate(phase_add(phase_cur, 2'd2), held_q, data_m[0]);
   assign hits        = term & en;

   always_comb begin
      pop = '0;
      for (int i = 0; i <= CHUNK; i++) begin
         pop = pop + PW'(hits[i]);
      end
   end

   assign red_or  = |hits;
   assign red_and = &(term | ~en);
   assign red_xor = ^hits;

   assign acc_base = first ? (mode_cur == 2'd1) : acc_q;
   assign cnt_base = first ? '0 : cnt_q;

   always_comb begin
      case (mode_cur)
         2'd1:    acc_new = acc_base & red_and;
         2'd2:    acc_new = acc_base ^ red_xor;
         default: acc_new = acc_base | red_or;
      endcase
   end

   assign cnt_sum = SW'(cnt_base) + SW'(pop);
   assign cnt_new = (cnt_sum > SW'(N_IN)) ? CW'(N_IN) : cnt_sum[CW-1:0];

   always_comb begin
      state_d = state_q;
      chunk_d = chunk_q;
      phase_d = phase_q;
      held_d  = held_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      f_d     = f_q;
      case (state_q)
         IDLE, LOAD: begin
            if (in_valid) begin
               acc_d   = acc_new;
               cnt_d   = cnt_new;
               held_d  = data_m[CHUNK-1];
               phase_d = phase_add(phase_cur, STEP);
               chunk_d = first ? CHW'(1) : chunk_q + CHW'(1);
               mode_d  = mode_cur;
               if (last) begin
                  state_d = DONE;
                  f_d     = (mode_cur == 2'd3) ? ~acc_new : acc_new;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         chunk_q <= '0;
         phase_q <= '0;
         held_q  <= 1'b0;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= '0;
         f_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         phase_q <= phase_d;
         held_q  <= held_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         f_q     <= f_d;
      end
   end

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign f         = f_q;
   assign cnt       = cnt_q;

endmodule

// File: tb/tb_pattern_reduce_stream.sv
// Scoreboard bench: a 230-bit/16-bit instance and a 7-bit/4-bit instance, directed frames with hand-computed results.
module tb_pattern_reduce_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, f;
   logic [15:0] in_data;
   logic [1:0]  mode;
   logic [7:0]  cnt;
   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_f;
   logic [3:0]  s_in_data;
   logic [1:0]  s_mode;
   logic [2:0]  s_cnt;

   pattern_reduce_stream #(.N_IN(230), .CHUNK(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .f(f), .cnt(cnt));

   pattern_reduce_stream #(.N_IN(7), .CHUNK(4)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .mode(s_mode), .out_valid(s_out_valid), .out_ready(s_out_ready), .f(s_f), .cnt(s_cnt));

   typedef struct packed {logic f; logic [7:0] cnt;} exp_t;
   exp_t exp_q[$];
   exp_t exp_s_q[$];
   exp_t mon_e, mon_s_e;
   int   checks = 0;
   int   errors = 0;

   localparam logic [239:0] ZEROS = '0;
   localparam logic [239:0] ONES  = '1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("big unexpected result", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("big f", 32'(f), 32'(mon_e.f));
            check("big cnt", 32'(cnt), 32'(mon_e.cnt));
         end
         $display("big result: f=%0d cnt=%0d", f, cnt);
      end
   end

   always @(negedge clk) begin
      if (!rst && s_out_valid && s_out_ready) begin
         if (exp_s_q.size() == 0) begin
            check("small unexpected result", 1, 0);
         end else begin
            mon_s_e = exp_s_q.pop_front();
            check("small f", 32'(s_f), 32'(mon_s_e.f));
            check("small cnt", 32'(s_cnt), 32'(mon_s_e.cnt));
         end
         $display("small result: f=%0d cnt=%0d", s_f, s_cnt);
      end
   end

   task automatic send_big(input logic [15:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         n++;
         if (n >= 50) begin
            check("big in_ready timeout", 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_small(input logic [3:0] d);
      int n;
      n = 0;
      s_in_valid = 1'b1;
      s_in_data  = d;
      forever begin
         @(negedge clk);
         if (s_in_ready === 1'b1) break;
         n++;
         if (n >= 50) begin
            check("small in_ready timeout", 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
   endtask

   // Mode is inverted after chunk 0 to confirm only the first beat's mode counts.
   task automatic frame_big(input logic [1:0] m, input logic [239:0] a, input logic ef,
                            input int ec, input int gap);
      exp_t e;
      e.f   = ef;
      e.cnt = 8'(ec);
      exp_q.push_back(e);
      $display("big frame: mode=%0d expect f=%0d cnt=%0d", m, ef, ec);
      mode = m;
      for (int k = 0; k < 15; k++) begin
         send_big(a[k*16 +: 16]);
         if (k == 0) mode = ~m;
         if (k < 14) repeat (gap) begin @(posedge clk); #1; end
      end
      @(negedge clk);
      check("big latency out_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
   endtask

   task automatic frame_small(input logic [1:0] m, input logic [7:0] a, input logic ef, input int ec);
      exp_t e;
      e.f   = ef;
      e.cnt = 8'(ec);
      exp_s_q.push_back(e);
      $display("small frame: mode=%0d expect f=%0d cnt=%0d", m, ef, ec);
      s_mode = m;
      send_small(a[3:0]);
      s_mode = ~m;
      send_small(a[7:4]);
      @(negedge clk);
      check("small latency out_valid", 32'(s_out_valid), 1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; mode = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_data = '0; s_mode = '0; s_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset big {in_ready,out_valid,f}", {29'd0, in_ready, out_valid, f}, 32'b100);
      check("reset big cnt", 32'(cnt), 0);
      check("reset small {in_ready,out_valid,f}", {29'd0, s_in_ready, s_out_valid, s_f}, 32'b100);
      check("reset small cnt", 32'(s_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      frame_big(2'd0, ZEROS, 1'b1, 77, 0);
      frame_big(2'd2, ZEROS, 1'b1, 77, 0);
      frame_big(2'd1, ZEROS, 1'b0, 77, 0);
      frame_big(2'd3, ZEROS, 1'b0, 77, 0);
      frame_big(2'd0, ONES, 1'b1, 153, 0);
      frame_big(2'd1, ONES, 1'b0, 153, 0);
      frame_big(2'd2, ONES, 1'b1, 153, 0);
      frame_big(2'd3, ONES, 1'b0, 153, 0);
      frame_big(2'd0, ZEROS | (240'd1 << 15), 1'b1, 78, 2);

      frame_small(2'd0, 8'hFF, 1'b1, 4);
      frame_small(2'd1, 8'hFF, 1'b0, 4);
      frame_small(2'd2, 8'hFF, 1'b0, 4);
      frame_small(2'd2, 8'h00, 1'b0, 2);

      // Backpressure: result held, input side closed, then released.
      out_ready = 1'b0;
      frame_big(2'd0, ZEROS, 1'b1, 77, 0);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'(i % 2);
         in_data  = 16'hFFFF;
         @(negedge clk);
         check("backpressure hold {out_valid,in_ready,f,cnt}",
               {21'd0, out_valid, in_ready, f, cnt}, {21'd0, 1'b1, 1'b0, 1'b1, 8'd77});
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("release {out_valid,in_ready}", {30'd0, out_valid, in_ready}, 32'b01);
      @(posedge clk); #1;
      frame_big(2'd1, ONES, 1'b0, 153, 0);

      // Abort a frame after chunk 5 with reset.
      mode = 2'd0;
      for (int k = 0; k < 6; k++) send_big(16'h0000);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid-frame reset {in_ready,out_valid}", {30'd0, in_ready, out_valid}, 32'b10);
      check("mid-frame reset cnt", 32'(cnt), 0);
      @(posedge clk); #1;
      frame_big(2'd0, ZEROS, 1'b1, 77, 0);

      repeat (5) @(posedge clk);
      check("big scoreboard drained", 32'(exp_q.size()), 0);
      check("small scoreboard drained", 32'(exp_s_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
